// File: rtl/spi_pwm_ctrl.sv
// SPI-programmable multi-channel PWM controller: SPI mode-0 slave register file driving NUM_CH PWM outputs.
// Optional MISO readback of the register map is enabled by defining SPI_PWM_READBACK_EN.
module spi_pwm_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int PWM_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              frame_done
);

    localparam logic [7:0] ID_VALUE = 8'hA5;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] live_q;
    logic                   sclk_prev_q;
    logic                   armed_q;

    logic sclk_s;
    logic mosi_s;
    logic cs_s;
    logic live;
    logic sclk_rise;
    logic frame_act;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       have_cmd_q, have_cmd_d;
    logic       is_wr_q, is_wr_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] byte_now;
    logic       wr_en;
    logic [7:0] wr_data;

    logic [NUM_CH-1:0] ctrl_q;
    logic [PWM_W-1:0]  period_q;
    logic [PWM_W-1:0]  duty_q [NUM_CH];
    logic [PWM_W-1:0]  dact_q [NUM_CH];
    logic [PWM_W-1:0]  cnt_q;
    logic [NUM_CH-1:0] pwm_q;
    logic              frame_done_q;
    logic              cnt_wrap;

    // Synchronisers reset to the idle bus state so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '1;
            live_q      <= '0;
            sclk_prev_q <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            live_q      <= {live_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            if (live && cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign live      = live_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    // A frame is only accepted once a genuine cs_n high has been observed after reset.
    assign frame_act = armed_q & ~cs_s;
    assign byte_now  = {shift_q, mosi_s};

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        have_cmd_d = have_cmd_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        if (!frame_act) begin
            bit_cnt_d  = 3'd0;
            have_cmd_d = 1'b0;
        end else if (sclk_rise) begin
            shift_d   = byte_now[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                if (!have_cmd_q) begin
                    have_cmd_d = 1'b1;
                    is_wr_d    = byte_now[7];
                    addr_d     = byte_now[6:0];
                end else begin
                    wr_en   = is_wr_q;
                    wr_data = byte_now;
                    addr_d  = addr_q + 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            have_cmd_q <= 1'b0;
            is_wr_q    <= 1'b0;
            addr_q     <= 7'd0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            have_cmd_q <= have_cmd_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            period_q     <= '1;
            frame_done_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i] <= '0;
            end
        end else begin
            frame_done_q <= wr_en;
            if (wr_en) begin
                if (addr_q == 7'd0) begin
                    ctrl_q <= wr_data[NUM_CH-1:0];
                end else if (addr_q == 7'd1) begin
                    period_q <= wr_data[PWM_W-1:0];
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (addr_q == 7'(i + 2)) begin
                        duty_q[i] <= wr_data[PWM_W-1:0];
                    end
                end
            end
        end
    end

    // A shrunk PERIOD below the current count makes the counter wrap on the next cycle.
    assign cnt_wrap = (cnt_q >= period_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            pwm_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                dact_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_wrap ? '0 : cnt_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= ctrl_q[i] & (cnt_q < dact_q[i]);
                if (cnt_wrap || !ctrl_q[i]) begin
                    dact_q[i] <= duty_q[i];
                end
            end
        end
    end

    assign pwm_out    = pwm_q;
    assign frame_done = frame_done_q;

`ifdef SPI_PWM_READBACK_EN
    logic       sclk_fall;
    logic       miso_q, miso_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] rd_data;

    function automatic logic [7:0] read_reg(input logic [6:0] a);
        logic [7:0] v;
        v = 8'h00;
        if (a == 7'd0) begin
            v[NUM_CH-1:0] = ctrl_q;
        end else if (a == 7'd1) begin
            v[PWM_W-1:0] = period_q;
        end else if (a == 7'h7F) begin
            v = ID_VALUE;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (a == 7'(i + 2)) begin
                    v[PWM_W-1:0] = duty_q[i];
                end
            end
        end
        return v;
    endfunction

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign rd_data   = read_reg(addr_q);

    // The falling edge that closes a byte (bit counter back at 0) loads the next readback byte.
    always_comb begin
        miso_d = miso_q;
        sr_d   = sr_q;
        if (!frame_act) begin
            miso_d = 1'b0;
            sr_d   = 8'h00;
        end else if (sclk_fall) begin
            if (!have_cmd_q || is_wr_q) begin
                miso_d = 1'b0;
                sr_d   = 8'h00;
            end else if (bit_cnt_q == 3'd0) begin
                miso_d = rd_data[7];
                sr_d   = {rd_data[6:0], 1'b0};
            end else begin
                miso_d = sr_q[7];
                sr_d   = {sr_q[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso_q <= 1'b0;
            sr_q   <= 8'h00;
        end else begin
            miso_q <= miso_d;
            sr_q   <= sr_d;
        end
    end

    assign spi_miso = miso_q & ~cs_s;
`else
    assign spi_miso = 1'b0;
`endif

endmodule
